spi_ram: RTL and testbench
==========================

SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of 8-bit memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, giving the address width taken from din.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port din, input, 10 bits, the command frame from the SPI slave: [9:8] opcode, [7:0] payload.
REQ-006 The block SHALL have port rx_valid, input, 1 bit, frame-valid from the SPI slave; it may stay high for several cycles.
REQ-007 The block SHALL have port tx_data, output, 8 bits, read data for the SPI slave to shift out MSB first.
REQ-008 The block SHALL have port tx_valid, output, 1 bit, high while tx_data holds valid read data.
REQ-009 The block SHALL have port cmd_err, output, 1 bit, one-cycle pulse flagging a rejected command.

Function
REQ-010 The block SHALL accept a command only on the first cycle rx_valid is high after a cycle it was low, so a held rx_valid yields one command.
REQ-011 Opcode 2'b00 SHALL load wr_addr from din[ADDR_SIZE-1:0] and set the wr_armed flag.
REQ-012 Opcode 2'b01 with wr_armed set SHALL write din[7:0] to mem[wr_addr] on the accept edge; with wr_armed clear it SHALL write nothing and pulse cmd_err.
REQ-013 Opcode 2'b10 SHALL load rd_addr from din[ADDR_SIZE-1:0], set rd_armed, and clear tx_valid.
REQ-014 Opcode 2'b11 with rd_armed set SHALL drive tx_data = mem[rd_addr] with tx_valid high one cycle after the accept edge; with rd_armed clear it SHALL pulse cmd_err and keep tx_valid low.
REQ-015 tx_valid SHALL stay high, tx_data stable, until the next accepted command; on that accept it SHALL drop unless the new command is a valid opcode 2'b11.
REQ-016 An address >= MEM_DEPTH SHALL cause a write to be dropped, or a read to return 8'h00 with tx_valid high, each with a cmd_err pulse.
REQ-017 With rx_valid low, or high but not newly accepted, no register or memory location SHALL change apart from cmd_err returning to 0.
REQ-018 cmd_err SHALL be registered, high exactly one cycle after the offending accept edge.

Reset
REQ-019 While rst is high on a clock edge, tx_data SHALL become 8'h00, tx_valid 0, cmd_err 0, wr_addr and rd_addr 0, wr_armed and rd_armed 0, and the rx_valid edge history 0.
REQ-020 Reset SHALL override any simultaneous command, and memory contents SHALL be unaffected by reset.
REQ-021 If rx_valid is high in the first cycle after reset release, that cycle SHALL count as a rising edge.

Configuration
REQ-022 With SPI_RAM_AUTOINC_EN defined, each successful data write SHALL increment wr_addr and each successful data read SHALL increment rd_addr, modulo MEM_DEPTH, with armed flags kept set.
REQ-023 Without SPI_RAM_AUTOINC_EN, wr_addr and rd_addr SHALL change only on opcodes 2'b00 and 2'b10, so repeated data commands target the same address.

Structure
REQ-024 Package spi_ram_pkg SHALL hold the opcode enum typedef (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the frame-width constants.
REQ-025 Storage SHALL be a sub-module spi_ram_mem with a synchronous write port and a synchronous read port and no reset; decode, flags and handshake SHALL stay in spi_ram.

Verification
REQ-026 The bench SHALL cover: frames 0x0A5 then 0x13C, then 0x2A5 then 0x300 -> tx_valid high one cycle after the last accept, tx_data = 0x3C.
REQ-027 The bench SHALL cover: 0x1FF after reset with no address frame -> no write, cmd_err high for exactly one cycle.
REQ-028 The bench SHALL cover: 0x010 with rx_valid held high for 5 cycles -> exactly one command accepted; with a write of 0x155 following, only mem[0x10] = 0x55 changes.
REQ-029 The bench SHALL cover: tx_valid high, then frame 0x000 -> tx_valid low on the cycle after the accept.
REQ-030 The bench SHALL cover, with SPI_RAM_AUTOINC_EN defined: 0x0FF, 0x111, 0x122 -> mem[0xFF] = 0x11 and mem[0x00] = 0x22; without it, mem[0xFF] = 0x22.
REQ-031 The bench SHALL cover: rst asserted in the same cycle as a valid 0x1xx accept -> no write, all outputs at their reset values.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcode enum and frame-width constants shared by spi_ram
// and its storage sub-module.
package spi_ram_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int OP_W    = 2;

   typedef enum logic [OP_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: MEM_DEPTH x 8 storage, sync write port, sync read port.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data (held).
module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_data
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // rd_data only moves on rd_en so it stays stable between reads
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/spi_ram.sv
// spi_ram: command decoder + RAM behind an SPI slave (10-bit frames).
// Ports: clk, rst (sync, active high), din, rx_valid -> tx_data,
// tx_valid, cmd_err. Option: SPI_RAM_AUTOINC_EN (post-increment addrs).
module spi_ram
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] din,
   input  logic               rx_valid,
   output logic [DATA_W-1:0]  tx_data,
   output logic               tx_valid,
   output logic               cmd_err
);

   localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

   logic                 rx_prev;
   logic                 wr_armed;
   logic                 rd_armed;
   logic                 tx_mem;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [DATA_W-1:0]    mem_rdata;

   logic                 accept;
   cmd_t                 op;
   logic [ADDR_SIZE-1:0] addr_in;
   logic                 wr_in;
   logic                 rd_in;
   logic                 mem_we;
   logic                 mem_re;

   assign accept  = rx_valid & ~rx_prev;
   assign op      = cmd_t'(din[FRAME_W-1 -: OP_W]);
   assign addr_in = din[ADDR_SIZE-1:0];
   assign wr_in   = 32'(wr_addr) < 32'(MEM_DEPTH);
   assign rd_in   = 32'(rd_addr) < 32'(MEM_DEPTH);

   // reset blocks any memory access in the same cycle
   assign mem_we = ~rst & accept & (op == CMD_WR_DATA)
                 & wr_armed & wr_in;
   assign mem_re = ~rst & accept & (op == CMD_RD_DATA)
                 & rd_armed & rd_in;

   // tx_mem low means "send zero": reset, dropped, or out-of-range read
   assign tx_data = tx_mem ? mem_rdata : '0;

   spi_ram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_addr),
      .wr_data (din[DATA_W-1:0]),
      .rd_en   (mem_re),
      .rd_addr (rd_addr),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_prev  <= 1'b0;
         wr_armed <= 1'b0;
         rd_armed <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         tx_valid <= 1'b0;
         tx_mem   <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         rx_prev <= rx_valid;
         cmd_err <= 1'b0;
         if (accept) begin
            // every accepted command drops tx unless it is a good read
            tx_valid <= 1'b0;
            tx_mem   <= 1'b0;
            unique case (op)
               CMD_WR_ADDR: begin
                  wr_addr  <= addr_in;
                  wr_armed <= 1'b1;
               end
               CMD_WR_DATA: begin
                  if (!wr_armed || !wr_in) begin
                     cmd_err <= 1'b1;
                  end else begin
`ifdef SPI_RAM_AUTOINC_EN
                     wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
`endif
                  end
               end
               CMD_RD_ADDR: begin
                  rd_addr  <= addr_in;
                  rd_armed <= 1'b1;
               end
               CMD_RD_DATA: begin
                  if (!rd_armed) begin
                     cmd_err <= 1'b1;
                  end else begin
                     tx_valid <= 1'b1;
                     tx_mem   <= rd_in;
                     if (!rd_in) begin
                        cmd_err <= 1'b1;
                     end else begin
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
`endif
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed self-checking bench for spi_ram.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_spi_ram;

   logic       clk;
   logic       rst;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;

   int checks;
   int errors;

   spi_ram #(
      .MEM_DEPTH (256),
      .ADDR_SIZE (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .cmd_err  (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one-cycle frame; returns on the negedge after the accept edge
   task automatic send(input logic [9:0] f);
      @(negedge clk);
      din      = f;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      send({2'b00, a});
      send({2'b01, d});
   endtask

   task automatic rd(input logic [7:0] a);
      send({2'b10, a});
      send({2'b11, a});
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_tx_data: got %h want 00", tx_data);
      end
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
      end
      checks++;
      if (cmd_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_cmd_err: got %b want 0", cmd_err);
      end
   endtask

   task automatic test_basic();
      send(10'h0A5);
      send(10'h13C);
      send(10'h2A5);
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_rdaddr_valid: got %b want 0", tx_valid);
      end
      send(10'h300);
      checks++;
      if (tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_tx_valid: got %b want 1", tx_valid);
      end
      checks++;
      if (tx_data !== 8'h3C) begin
         errors++;
         $display("FAIL basic_tx_data: got %h want 3c", tx_data);
      end
      checks++;
      if (cmd_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_cmd_err: got %b want 0", cmd_err);
      end
   endtask

   task automatic test_hold();
      repeat (3) @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
         errors++;
         $display("FAIL hold_tx: got %b/%h want 1/3c",
                  tx_valid, tx_data);
      end
   endtask

   task automatic test_drop();
      send(10'h000);
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_tx_valid: got %b want 0", tx_valid);
      end
   endtask

   task automatic test_wr_no_addr();
      do_reset();
      wr(8'h00, 8'h5A);
      do_reset();
      send(10'h1FF);
      checks++;
      if (cmd_err !== 1'b1) begin
         errors++;
         $display("FAIL noaddr_err_hi: got %b want 1", cmd_err);
      end
      @(negedge clk);
      checks++;
      if (cmd_err !== 1'b0) begin
         errors++;
         $display("FAIL noaddr_err_lo: got %b want 0", cmd_err);
      end
      rd(8'h00);
      checks++;
      if (tx_data !== 8'h5A) begin
         errors++;
         $display("FAIL noaddr_mem0: got %h want 5a", tx_data);
      end
   endtask

   task automatic test_held_rx();
      do_reset();
      wr(8'h0F, 8'h00);
      wr(8'h10, 8'h00);
      wr(8'h11, 8'h00);
      @(negedge clk);
      din      = 10'h010;
      rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL held_err c%0d: got %b want 0", i, cmd_err);
         end
      end
      rx_valid = 1'b0;
      send(10'h155);
      rd(8'h10);
      checks++;
      if (tx_data !== 8'h55) begin
         errors++;
         $display("FAIL held_mem10: got %h want 55", tx_data);
      end
      rd(8'h11);
      checks++;
      if (tx_data !== 8'h00) begin
         errors++;
         $display("FAIL held_mem11: got %h want 00", tx_data);
      end
      rd(8'h0F);
      checks++;
      if (tx_data !== 8'h00) begin
         errors++;
         $display("FAIL held_mem0f: got %h want 00", tx_data);
      end
      // frame changes while rx_valid stays high: only first is taken
      send(10'h011);
      @(negedge clk);
      din      = 10'h1A1;
      rx_valid = 1'b1;
      @(negedge clk);
      din = 10'h1B2;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      rd(8'h11);
      checks++;
      if (tx_data !== 8'hA1) begin
         errors++;
         $display("FAIL held_change: got %h want a1", tx_data);
      end
   endtask

   task automatic test_autoinc();
      do_reset();
      wr(8'h00, 8'h99);
      send(10'h0FF);
      send(10'h111);
      send(10'h122);
`ifdef SPI_RAM_AUTOINC_EN
      rd(8'hFF);
      checks++;
      if (tx_data !== 8'h11) begin
         errors++;
         $display("FAIL ainc_memff: got %h want 11", tx_data);
      end
      send(10'h300);
      checks++;
      if (tx_data !== 8'h22) begin
         errors++;
         $display("FAIL ainc_rd_wrap: got %h want 22", tx_data);
      end
      rd(8'h00);
      checks++;
      if (tx_data !== 8'h22) begin
         errors++;
         $display("FAIL ainc_mem00: got %h want 22", tx_data);
      end
`else
      rd(8'hFF);
      checks++;
      if (tx_data !== 8'h22) begin
         errors++;
         $display("FAIL noinc_memff: got %h want 22", tx_data);
      end
      rd(8'h00);
      checks++;
      if (tx_data !== 8'h99) begin
         errors++;
         $display("FAIL noinc_mem00: got %h want 99", tx_data);
      end
      send(10'h300);
      checks++;
      if (tx_data !== 8'h99) begin
         errors++;
         $display("FAIL noinc_rd_again: got %h want 99", tx_data);
      end
`endif
   endtask

   task automatic test_reset_override();
      do_reset();
      wr(8'h20, 8'h81);
      send(10'h020);
      rd(8'h20);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin
         errors++;
         $display("FAIL ovr_pre: got %b/%h want 1/81",
                  tx_valid, tx_data);
      end
      @(negedge clk);
      din      = 10'h1AB;
      rx_valid = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || cmd_err !== 1'b0)
      begin
         errors++;
         $display("FAIL ovr_outputs: got %b/%h/%b want 0/00/0",
                  tx_valid, tx_data, cmd_err);
      end
      rst      = 1'b0;
      rx_valid = 1'b0;
      send(10'h300);
      checks++;
      if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovr_rd_unarmed: got err %b vld %b want 1/0",
                  cmd_err, tx_valid);
      end
      send(10'h1CD);
      checks++;
      if (cmd_err !== 1'b1) begin
         errors++;
         $display("FAIL ovr_wr_unarmed: got %b want 1", cmd_err);
      end
      rd(8'h20);
      checks++;
      if (tx_data !== 8'h81) begin
         errors++;
         $display("FAIL ovr_mem20: got %h want 81", tx_data);
      end
   endtask

   task automatic test_rx_after_reset();
      @(negedge clk);
      rst      = 1'b1;
      din      = 10'h220;
      rx_valid = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      send(10'h300);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h81 || cmd_err !== 1'b0)
      begin
         errors++;
         $display("FAIL post_rst_edge: got %b/%h/%b want 1/81/0",
                  tx_valid, tx_data, cmd_err);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      din      = '0;
      rx_valid = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_drop();
      test_wr_no_addr();
      test_held_rx();
      test_autoinc();
      test_reset_override();
      test_rx_after_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
